// File: rtl/vecmac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vecmac_pkg
// Description : Shared types and constants for the vector-MAC accumulation
//               stage: input sum width, FSM state encoding and the result
//               record carried from the accumulator to the output port.
// Revision    : 1.0 - initial release
// ============================================================================
package vecmac_pkg;

    // Width of one unsigned 4-lane dot-product sum from the Wallace stage.
    localparam int SUM_W = 18;

    // Widest accumulator the result record can carry.
    localparam int ACC_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // One finished accumulation. acc is zero-extended from the configured
    // accumulator width; sat is set when the accumulation was clamped.
    typedef struct packed {
        logic [ACC_MAX_W-1:0] acc;
        logic                 sat;
    } vecmac_result_t;

endpackage : vecmac_pkg
`default_nettype wire

// File: rtl/vecmac_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vecmac_result_fifo
// Description : Synchronous show-ahead FIFO. data_o always presents the head
//               entry while not empty. A push while full is accepted only when
//               a pop happens in the same cycle (occupancy stays unchanged).
// Ports       : clk_i    - rising-edge clock
//               rst_ni   - synchronous active-low reset (empties the FIFO)
//               push_i   - write request, data_i captured when accepted
//               data_i   - write data
//               pop_i    - remove head entry (ignored when empty)
//               data_o   - head entry
//               full_o   - DEPTH entries held
//               empty_o  - no entries held
// Revision    : 1.0 - initial release
// ============================================================================
module vecmac_result_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;

    logic w_wr_en;
    logic w_rd_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign w_rd_en = pop_i && !empty_o;
    // When full, the slot being freed by a simultaneous pop is the one the
    // write pointer addresses, so the push can land there.
    assign w_wr_en = push_i && (!full_o || w_rd_en);
    assign data_o  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once written.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule : vecmac_result_fifo
`default_nettype wire

// File: rtl/vecmac_accum.sv
`default_nettype none
// ============================================================================
// Module      : vecmac_accum
// Description : Accumulates a programmed number of 18-bit unsigned dot-product
//               sums into an ACC_W-bit result and queues finished results in a
//               show-ahead FIFO behind a ready/valid port. The input is never
//               back-pressured; dropped results and stray traffic are flagged
//               through sticky error bits.
// Config      : VECMAC_ACC_SAT_EN - when defined, accumulation saturates at
//               all-ones and reports it on out_sat_o; otherwise it wraps and
//               out_sat_o is 0.
// Ports       : clk_i           - rising-edge clock
//               rst_ni          - synchronous active-low reset
//               cfg_start_i     - start pulse, cfg_len_i sampled with it
//               cfg_len_i       - number of sums in the accumulation
//               in_valid_i      - in_sum_i valid (always consumed/discarded)
//               in_sum_i        - unsigned dot-product sum
//               busy_o          - accumulation in progress (ACCUM or FLUSH)
//               out_valid_o     - head result valid
//               out_ready_i     - consumer accepts head result
//               out_acc_o       - head accumulated result
//               out_sat_o       - head result was saturated
//               err_overflow_o  - sticky: finished result dropped, FIFO full
//               err_stray_o     - sticky: in_valid idle / cfg_start busy
// Revision    : 1.0 - initial release
// ============================================================================
module vecmac_accum
    import vecmac_pkg::*;
#(
    parameter int ACC_W      = 32,  // 18 .. ACC_MAX_W
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4    // power of two, >= 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_start_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    input  logic             in_valid_i,
    input  logic [SUM_W-1:0] in_sum_i,
    output logic             busy_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] out_acc_o,
    output logic             out_sat_o,
    output logic             err_overflow_o,
    output logic             err_stray_o
);

`ifdef VECMAC_ACC_SAT_EN
    localparam int RES_W = ACC_W + 1;
`else
    localparam int RES_W = ACC_W;
`endif

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_stray_q, err_stray_d;
`ifdef VECMAC_ACC_SAT_EN
    logic             sat_q, sat_d;
    logic [ACC_W:0]   w_sum_ext;   // carry bit detects overflow
`endif

    logic             w_push;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [RES_W-1:0] w_push_data;
    logic [RES_W-1:0] w_head_data;
    vecmac_result_t   w_head_res;
    logic             w_unused_acc;

    // ------------------------------------------------------------------
    // FSM, accumulator and remaining-count next state
    // ------------------------------------------------------------------
`ifdef VECMAC_ACC_SAT_EN
    assign w_sum_ext = {1'b0, acc_q} + (ACC_W+1)'(in_sum_i);
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        err_ovf_d   = err_ovf_q;
        err_stray_d = err_stray_q;
        w_push      = 1'b0;
`ifdef VECMAC_ACC_SAT_EN
        sat_d       = sat_q;
`endif
        case (state_q)
            IDLE: begin
                // No accumulation is open, so any sum is discarded.
                if (in_valid_i) begin
                    err_stray_d = 1'b1;
                end
                if (cfg_start_i) begin
                    acc_d = '0;
                    rem_d = cfg_len_i;
`ifdef VECMAC_ACC_SAT_EN
                    sat_d = 1'b0;
`endif
                    // A zero-length job still produces a (zero) result.
                    state_d = (cfg_len_i != '0) ? ACCUM : FLUSH;
                end
            end
            ACCUM: begin
                if (cfg_start_i) begin
                    err_stray_d = 1'b1;
                end
                if (in_valid_i) begin
`ifdef VECMAC_ACC_SAT_EN
                    if (w_sum_ext[ACC_W]) begin
                        acc_d = '1;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = w_sum_ext[ACC_W-1:0];
                    end
`else
                    acc_d = acc_q + ACC_W'(in_sum_i);
`endif
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (cfg_start_i) begin
                    err_stray_d = 1'b1;
                end
                w_push = 1'b1;
                // A same-cycle pop frees a slot, so full alone is not a drop.
                if (w_fifo_full && !w_pop) begin
                    err_ovf_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            rem_q       <= '0;
            err_ovf_q   <= 1'b0;
            err_stray_q <= 1'b0;
`ifdef VECMAC_ACC_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            err_ovf_q   <= err_ovf_d;
            err_stray_q <= err_stray_d;
`ifdef VECMAC_ACC_SAT_EN
            sat_q       <= sat_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
`ifdef VECMAC_ACC_SAT_EN
    assign w_push_data     = {acc_q, sat_q};
    assign w_head_res.acc  = ACC_MAX_W'(w_head_data[ACC_W:1]);
    assign w_head_res.sat  = w_head_data[0];
`else
    assign w_push_data     = acc_q;
    assign w_head_res.acc  = ACC_MAX_W'(w_head_data);
    assign w_head_res.sat  = 1'b0;
`endif

    assign w_pop = out_valid_o && out_ready_i;

    vecmac_result_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .data_i  (w_push_data),
        .pop_i   (w_pop),
        .data_o  (w_head_data),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // Zero-extension bits of the record carry no information.
    assign w_unused_acc = ^w_head_res.acc;

    // ------------------------------------------------------------------
    // Outputs; the result is masked while empty so unwritten storage
    // never reaches the port.
    // ------------------------------------------------------------------
    assign busy_o         = (state_q != IDLE);
    assign out_valid_o    = !w_fifo_empty;
    assign out_acc_o      = out_valid_o ? w_head_res.acc[ACC_W-1:0] : '0;
    assign out_sat_o      = out_valid_o & w_head_res.sat;
    assign err_overflow_o = err_ovf_q;
    assign err_stray_o    = err_stray_q;

endmodule : vecmac_accum
`default_nettype wire

// File: doc/vecmac_accum.md
# vecmac_accum

Downstream accumulation stage of the int8 vector-MAC datapath. Consumes the 18-bit unsigned 4-lane dot-product sums produced by the four-multiplier Wallace stage, accumulates a programmed number of them (one per 4-element chunk) into a wide result, and queues finished results in a small FIFO behind a ready/valid output. The upstream multiplier pipeline cannot stall, so this block never back-pressures its input; it flags loss instead.

## Interface
- ACC_W, 32: accumulator/result width; must be ≥ 18.
- LEN_W, 16: width of the chunk-count field.
- FIFO_DEPTH, 4: result FIFO entries; power of two, ≥ 2.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- cfg_start  in  1  one-cycle command pulse: begin a new accumulation.
- cfg_len  in  LEN_W  number of input sums in this accumulation, sampled with cfg_start.
- in_valid  in  1  in_sum is valid this cycle (no ready; always consumed or discarded).
- in_sum  in  18  unsigned 4-lane dot-product sum.
- busy  out  1  accumulation in progress.
- out_valid  out  1  head-of-FIFO result valid.
- out_ready  in  1  consumer accepts out_acc this cycle.
- out_acc  out  ACC_W  accumulated result.
- out_sat  out  1  result accompanying out_acc saturated (see Configuration).
- err_overflow  out  1  sticky: a finished result was dropped because the FIFO was full.
- err_stray  out  1  sticky: in_valid while idle, or cfg_start while busy.

## Operation
- States: IDLE, ACCUM, FLUSH.
- IDLE: cfg_start → acc ← 0, remaining ← cfg_len; next ACCUM if cfg_len ≠ 0, else FLUSH with acc = 0. in_valid in IDLE (including the cfg_start cycle) is discarded and sets err_stray.
- ACCUM: each in_valid: acc ← acc + zero-extended in_sum, remaining ← remaining − 1. When in_valid arrives with remaining == 1, the final sum is added and state → FLUSH.
- FLUSH (one cycle): push {acc, sat} into FIFO if not full, else drop and set err_overflow; state → IDLE.
- cfg_start while busy is ignored and sets err_stray; the running accumulation is unaffected.
- FIFO: show-ahead; pop when out_valid && out_ready; push and pop in the same cycle allowed (count unchanged, even when full).
- Sticky errors clear only on reset.
- Arithmetic: unsigned; without saturation, acc wraps modulo 2^ACC_W.

## Timing
- Reset (rst_n low at a clock edge): state IDLE, acc 0, remaining 0, FIFO empty; busy 0, out_valid 0, out_acc 0, out_sat 0, err_overflow 0, err_stray 0. Reset mid-accumulation discards partial acc and all queued results.
- busy = 1 from the cycle after accepted cfg_start through the FLUSH cycle inclusive; 0 in IDLE.
- Final in_sum at cycle N → FLUSH at N+1 → out_valid at N+2 (FIFO previously empty). cfg_len = 0: cfg_start at N → out_valid with 0 at N+2.
- Next cfg_start accepted at earliest N+2 (first IDLE cycle after FLUSH).
- in_valid may be asserted every cycle; gaps allowed.
- out_acc/out_sat hold stable while out_valid && !out_ready.

## Configuration
- VECMAC_ACC_SAT_EN defined: an add whose true result exceeds 2^ACC_W − 1 clamps acc to all-ones and sets a per-accumulation sat bit, stored with the result and presented on out_sat; subsequent adds keep acc clamped.
- Undefined: acc wraps; out_sat tied to 0; no saturation logic synthesised.

## Structure
- Package vecmac_pkg: SUM_W = 18 constant, state enum type (IDLE/ACCUM/FLUSH), result struct {acc, sat}.
- One sub-module: vecmac_result_fifo (synchronous show-ahead FIFO, parameterised width/depth, full/empty, simultaneous push/pop).
- Accumulator, counter and FSM live in the top module.

## Test plan
- cfg_len=3, sums 100, 200, 300 back-to-back → single result 600, out_valid two cycles after last sum, busy low thereafter.
- cfg_len=0 → result 0 at cfg_start+2; no in_valid required.
- ACC_W=18, cfg_len=2, sums 260100 and 260100 → out_acc 258056 (wrap) with macro off; 262143 and out_sat=1 with macro on.
- out_ready held 0, five accumulations of cfg_len=1 (sums 1..5), FIFO_DEPTH=4 → err_overflow=1, then draining yields 1,2,3,4 in order.
- in_valid while idle and cfg_start during ACCUM → err_stray=1, running result unchanged and correct.
- rst_n low mid-ACCUM with two results queued → all outputs zero next cycle, FIFO empty, new accumulation then correct.
